// File: rtl/idelay_sweep_ctrl.sv
// Sweeps the IDELAYE2 tap (VAR_LOAD) from a start to an end value, one point per trigger,
// loading each tap with a one-cycle LD strobe and reporting it usable after a settle time.
module idelay_sweep_ctrl #(
    parameter int TAP_W      = 5,
    parameter int SETTLE_W   = 8,
    parameter int SETTLE_DEF = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [TAP_W-1:0]    cfg_start,
    input  logic [TAP_W-1:0]    cfg_end,
    input  logic [TAP_W-1:0]    cfg_step,
    input  logic [SETTLE_W-1:0] cfg_settle,
    input  logic                cfg_wrap,
    input  logic                sweep_start,
    input  logic                abort,
    input  logic                trig,
    input  logic                ctrl_rdy,
    output logic [TAP_W-1:0]    dly_cntvalue,
    output logic                dly_ld,
    output logic                dly_ready,
    output logic                busy,
    output logic                sweep_done,
    output logic                trig_miss,
    output logic                cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_LOAD,
        S_SETTLE,
        S_ARMED
    } state_t;

    state_t                state, state_nxt;
    logic [TAP_W-1:0]      tap_cur, tap_nxt;
    logic [SETTLE_W-1:0]   cnt, cnt_nxt;
    logic [TAP_W-1:0]      start_r, end_r, step_r;
    logic [SETTLE_W-1:0]   settle_r;
    logic                  wrap_r;
    logic                  cfg_ld;
    logic                  done_nxt, miss_nxt, err_nxt;
    logic [TAP_W-1:0]      step_eff;
    logic [TAP_W:0]        tap_sum;
    logic                  last_point;

    // One bit wider than the tap so a step past the top is seen, not wrapped.
    assign step_eff   = (step_r == '0) ? TAP_W'(1) : step_r;
    assign tap_sum    = {1'b0, tap_cur} + {1'b0, step_eff};
    assign last_point = (tap_sum > {1'b0, end_r}) || (tap_cur >= end_r);

    always_comb begin
        state_nxt = state;
        tap_nxt   = tap_cur;
        cnt_nxt   = cnt;
        cfg_ld    = 1'b0;
        done_nxt  = 1'b0;
        miss_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    cfg_ld = cfg_we;
                    if (sweep_start) begin
                        state_nxt = S_WAIT_RDY;
                        tap_nxt   = start_r;
                    end
                end
                S_WAIT_RDY: begin
                    if (ctrl_rdy) state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    if (settle_r == '0) begin
                        state_nxt = S_ARMED;
                    end else begin
                        state_nxt = S_SETTLE;
                        cnt_nxt   = settle_r - SETTLE_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (!ctrl_rdy)      state_nxt = S_WAIT_RDY;
                    else if (cnt == '0) state_nxt = S_ARMED;
                    else                cnt_nxt   = cnt - SETTLE_W'(1);
                end
                S_ARMED: begin
                    if (trig) begin
                        if (last_point) begin
                            done_nxt = 1'b1;
                            if (wrap_r) begin
                                tap_nxt   = start_r;
                                state_nxt = ctrl_rdy ? S_LOAD : S_WAIT_RDY;
                            end else begin
                                state_nxt = S_IDLE;
                            end
                        end else begin
                            tap_nxt   = tap_sum[TAP_W-1:0];
                            state_nxt = ctrl_rdy ? S_LOAD : S_WAIT_RDY;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
            if (state != S_IDLE) begin
                miss_nxt = trig && (state != S_ARMED);
                err_nxt  = cfg_we;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            tap_cur      <= '0;
            cnt          <= '0;
            dly_cntvalue <= '0;
            sweep_done   <= 1'b0;
            trig_miss    <= 1'b0;
            cfg_err      <= 1'b0;
            start_r      <= '0;
            end_r        <= '1;
            step_r       <= TAP_W'(1);
            settle_r     <= SETTLE_W'(SETTLE_DEF);
            wrap_r       <= 1'b0;
        end else begin
            state      <= state_nxt;
            tap_cur    <= tap_nxt;
            cnt        <= cnt_nxt;
            sweep_done <= done_nxt;
            trig_miss  <= miss_nxt;
            cfg_err    <= err_nxt;
            // The tap reaches CNTVALUEIN on the edge entering LOAD, so it is stable under LD.
            if (state_nxt == S_LOAD) dly_cntvalue <= tap_nxt;
            if (cfg_ld) begin
                start_r  <= cfg_start;
                end_r    <= cfg_end;
                step_r   <= cfg_step;
                settle_r <= cfg_settle;
                wrap_r   <= cfg_wrap;
            end
        end
    end

    assign dly_ld    = (state == S_LOAD);
    assign dly_ready = (state == S_ARMED);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_idelay_sweep_ctrl.sv
// Self-checking bench for idelay_sweep_ctrl: directed scenarios plus random traffic,
// every cycle compared against a timestamp-based behavioural model of the sweep.
module tb_idelay_sweep_ctrl;
    localparam int TAP_W      = 5;
    localparam int SETTLE_W   = 8;
    localparam int SETTLE_DEF = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_we = 1'b0;
    logic [TAP_W-1:0]    cfg_start = '0, cfg_end = '0, cfg_step = '0;
    logic [SETTLE_W-1:0] cfg_settle = '0;
    logic                cfg_wrap = 1'b0;
    logic                sweep_start = 1'b0, abort = 1'b0, trig = 1'b0, ctrl_rdy = 1'b1;
    logic [TAP_W-1:0]    dly_cntvalue;
    logic                dly_ld, dly_ready, busy, sweep_done, trig_miss, cfg_err;

    always #5 clk = ~clk;

    idelay_sweep_ctrl #(.TAP_W(TAP_W), .SETTLE_W(SETTLE_W), .SETTLE_DEF(SETTLE_DEF)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_start(cfg_start), .cfg_end(cfg_end),
        .cfg_step(cfg_step), .cfg_settle(cfg_settle), .cfg_wrap(cfg_wrap),
        .sweep_start(sweep_start), .abort(abort), .trig(trig), .ctrl_rdy(ctrl_rdy),
        .dly_cntvalue(dly_cntvalue), .dly_ld(dly_ld), .dly_ready(dly_ready), .busy(busy),
        .sweep_done(sweep_done), .trig_miss(trig_miss), .cfg_err(cfg_err)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Behavioural model: the sweep is tracked as "waiting to load", "loaded at time ldt",
    // "usable from ldt+settle+1" rather than as a state machine.
    int m_start, m_end, m_step, m_settle, m_wrap;
    int m_tap, m_cv, m_ldt;
    bit m_busy, m_ld, m_armed, m_pend, m_done, m_miss, m_err;

    task automatic model_reset();
        m_start = 0; m_end = 31; m_step = 1; m_settle = SETTLE_DEF; m_wrap = 0;
        m_tap = 0; m_cv = 0; m_ldt = 0;
        m_busy = 0; m_ld = 0; m_armed = 0; m_pend = 0;
        m_done = 0; m_miss = 0; m_err = 0;
    endtask

    task automatic model_load_point(input int n);
        m_armed = 0;
        if (ctrl_rdy) begin
            m_ld = 1; m_cv = m_tap; m_ldt = n + 1;
        end else begin
            m_pend = 1;
        end
    endtask

    task automatic model_step(input int n);
        int st, nxt;
        m_done = 0; m_miss = 0; m_err = 0;
        if (abort) begin
            m_busy = 0; m_ld = 0; m_armed = 0; m_pend = 0;
        end else if (!m_busy) begin
            if (sweep_start) begin
                m_busy = 1; m_tap = m_start; m_pend = 1;
            end
            if (cfg_we) begin
                m_start = cfg_start; m_end = cfg_end; m_step = cfg_step;
                m_settle = cfg_settle; m_wrap = cfg_wrap;
            end
        end else begin
            m_err  = cfg_we;
            m_miss = trig && !m_armed;
            if (m_ld) begin
                m_ld = 0;
                if (m_settle == 0) m_armed = 1;
            end else if (m_pend) begin
                if (ctrl_rdy) begin
                    m_pend = 0; m_ld = 1; m_cv = m_tap; m_ldt = n + 1;
                end
            end else if (m_armed) begin
                if (trig) begin
                    st  = (m_step == 0) ? 1 : m_step;
                    nxt = m_tap + st;
                    if (nxt > m_end || m_tap >= m_end) begin
                        m_done = 1;
                        if (m_wrap != 0) begin
                            m_tap = m_start;
                            model_load_point(n);
                        end else begin
                            m_busy = 0; m_armed = 0;
                        end
                    end else begin
                        m_tap = nxt;
                        model_load_point(n);
                    end
                end
            end else begin
                if (!ctrl_rdy) m_pend = 1;
                else if (n + 1 == m_ldt + m_settle + 1) m_armed = 1;
            end
        end
    endtask

    function automatic logic [15:0] obs_vec();
        return {5'b0, dly_cntvalue, dly_ld, dly_ready, busy, sweep_done, trig_miss, cfg_err};
    endfunction

    function automatic logic [15:0] exp_vec();
        logic [4:0] cv;
        cv = 5'(m_cv);
        return {5'b0, cv, m_ld, m_armed, m_busy, m_done, m_miss, m_err};
    endfunction

    // Inputs are already applied (at a negedge); advance one clock and compare at the next negedge.
    task automatic tick();
        model_step(cyc);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("cycle", obs_vec(), exp_vec());
    endtask

    task automatic clear_pulses();
        cfg_we = 0; sweep_start = 0; abort = 0; trig = 0;
    endtask

    task automatic write_cfg(input int s, input int e, input int st, input int se, input bit w);
        cfg_start = 5'(s); cfg_end = 5'(e); cfg_step = 5'(st); cfg_settle = 8'(se); cfg_wrap = w;
        cfg_we = 1; tick(); cfg_we = 0;
    endtask

    task automatic pulse_start();
        sweep_start = 1; tick(); sweep_start = 0;
    endtask

    task automatic pulse_trig();
        trig = 1; tick(); trig = 0;
    endtask

    task automatic pulse_abort();
        abort = 1; tick(); abort = 0;
    endtask

    task automatic wait_ready(input int max);
        int k = 0;
        while (!dly_ready && k < max) begin
            tick();
            k++;
        end
        chk("ready_timeout", 16'(dly_ready), 16'd1);
    endtask

    task automatic rst_pulse();
        #2 rst = 1;
        #1 chk("rst_async", obs_vec(), 16'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold", obs_vec(), 16'd0);
        rst = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", obs_vec(), 16'd0);
        rst = 0;

        // Scenario 1: latency and a three-point sweep without wrap
        ctrl_rdy = 1;
        write_cfg(0, 4, 2, 3, 0);
        pulse_start();
        tick();
        chk("s1_ld_cycle2", {dly_cntvalue, dly_ld}, {5'd0, 1'b1});
        repeat (3) tick();
        chk("s1_not_ready_c5", 16'(dly_ready), 16'd0);
        tick();
        chk("s1_ready_c6", 16'(dly_ready), 16'd1);
        pulse_trig();
        chk("s1_tap2", {dly_cntvalue, dly_ld}, {5'd2, 1'b1});
        wait_ready(20);
        pulse_trig();
        chk("s1_tap4", {dly_cntvalue, dly_ld}, {5'd4, 1'b1});
        wait_ready(20);
        pulse_trig();
        chk("s1_done_idle", {sweep_done, busy}, 2'b10);

        // Scenario 2: step past the top ends the sweep and wraps to start, not to tap 1
        write_cfg(28, 31, 5, 1, 1);
        pulse_start();
        wait_ready(20);
        chk("s2_first_tap", 16'(dly_cntvalue), 16'd28);
        pulse_trig();
        chk("s2_wrap", {sweep_done, dly_ld, dly_cntvalue}, {1'b1, 1'b1, 5'd28});
        pulse_abort();

        // Scenario 3: ctrl_rdy gating and a settle interrupted by ctrl_rdy falling
        write_cfg(10, 20, 1, 8, 0);
        ctrl_rdy = 0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("s3_no_ld", 16'(dly_ld), 16'd0);
        end
        ctrl_rdy = 1;
        tick();
        chk("s3_ld_after_rdy", 16'(dly_ld), 16'd1);
        tick();
        tick();
        ctrl_rdy = 0;
        tick();
        chk("s3_back_to_wait", {busy, dly_ld, dly_ready}, 3'b100);
        ctrl_rdy = 1;
        tick();
        chk("s3_ld_reissued", {dly_ld, dly_cntvalue}, {1'b1, 5'd10});

        // Scenario 4: trig while settling is a miss, trig while armed advances
        tick();
        pulse_trig();
        chk("s4_miss", {trig_miss, dly_cntvalue}, {1'b1, 5'd10});
        wait_ready(20);
        pulse_trig();
        chk("s4_advance", {dly_ld, dly_cntvalue}, {1'b1, 5'd11});
        pulse_abort();

        // Scenario 5: abort during settle holds the tap; writes while busy are dropped
        write_cfg(7, 20, 1, 8, 0);
        pulse_start();
        tick();
        tick();
        pulse_abort();
        chk("s5_abort", {busy, dly_ready, sweep_done, dly_cntvalue}, {3'b000, 5'd7});
        pulse_start();
        cfg_start = 5'd1; cfg_end = 5'd2; cfg_we = 1;
        tick();
        cfg_we = 0;
        chk("s5_cfg_err", 16'(cfg_err), 16'd1);
        pulse_abort();
        pulse_start();
        tick();
        chk("s5_cfg_kept", {dly_ld, dly_cntvalue}, {1'b1, 5'd7});
        pulse_abort();

        // Scenario 6: step 0 acts as 1; asynchronous reset while armed
        write_cfg(3, 5, 0, 0, 0);
        pulse_start();
        for (int t = 3; t <= 5; t++) begin
            wait_ready(20);
            chk("s6_tap", 16'(dly_cntvalue), 16'(t));
            if (t < 5) pulse_trig();
        end
        rst_pulse();

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                clear_pulses();
                rst_pulse();
            end
            cfg_we      = ($urandom_range(0, 19) == 0);
            cfg_start   = 5'($urandom);
            cfg_end     = 5'($urandom);
            cfg_step    = 5'($urandom_range(0, 7));
            cfg_settle  = 8'($urandom_range(0, 6));
            cfg_wrap    = 1'($urandom);
            sweep_start = ($urandom_range(0, 7) == 0);
            abort       = ($urandom_range(0, 59) == 0);
            trig        = ($urandom_range(0, 3) == 0);
            ctrl_rdy    = ($urandom_range(0, 9) != 0);
            tick();
        end
        clear_pulses();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
